// File: rtl/jogo_pkg.sv
// Shared state codes, output bundle and decode helpers for the quiz game controller.
package jogo_pkg;

    localparam int unsigned NUM_RODADAS      = 8;
    localparam int unsigned MAX_ERROS_PADRAO = 3;

    typedef enum logic [3:0] {
        StInicial      = 4'h0,
        StPrepara      = 4'h1,
        StMostra       = 4'h2,
        StZeraT        = 4'h3,
        StEspera       = 4'h4,
        StRegistra     = 4'h5,
        StCompara      = 4'h6,
        StAcerto       = 4'h7,
        StContaAcerto  = 4'h8,
        StResultAcerto = 4'h9,
        StErro         = 4'hA,
        StResultErro   = 4'hB,
        StProxima      = 4'hC,
        StFim          = 4'hD
    } estado_t;

    typedef struct packed {
        logic zera_contador_jogada;
        logic zera_contador_score;
        logic zera_timer_resultado;
        logic zera_timeout;
        logic zeraR;
        logic zera_tempo_de_jogo;
        logic conta_score;
        logic conta_timer_resultado;
        logic conta_timeout;
        logic registraR;
        logic liga_led;
        logic mostra_tempo_de_jogo;
        logic acertou;
        logic errou;
        logic pronto;
    } saidas_t;

    function automatic saidas_t decodifica_saidas(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            StPrepara: begin
                s.zera_contador_jogada = 1'b1;
                s.zera_contador_score  = 1'b1;
                s.zera_timer_resultado = 1'b1;
                s.zera_timeout         = 1'b1;
                s.zeraR                = 1'b1;
                s.zera_tempo_de_jogo   = 1'b1;
            end
            StMostra: begin
                s.liga_led              = 1'b1;
                s.conta_timer_resultado = 1'b1;
            end
            StZeraT: begin
                s.zera_timer_resultado = 1'b1;
                s.zera_timeout         = 1'b1;
                s.zeraR                = 1'b1;
            end
            StEspera:      s.conta_timeout = 1'b1;
            StRegistra:    s.registraR     = 1'b1;
            StContaAcerto: s.conta_score   = 1'b1;
            StResultAcerto: begin
                s.acertou               = 1'b1;
                s.conta_timer_resultado = 1'b1;
            end
            StResultErro: begin
                s.errou                 = 1'b1;
                s.conta_timer_resultado = 1'b1;
            end
            StProxima:     s.zera_timer_resultado = 1'b1;
            StFim: begin
                s.pronto               = 1'b1;
                s.mostra_tempo_de_jogo = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

    // States in which a pause request freezes the game.
    function automatic logic estado_pausavel(estado_t e);
        return (e == StMostra) || (e == StEspera) || (e == StResultAcerto) || (e == StResultErro);
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game controller (master) and the datapath/player (slave).
interface unidade_controle_jogo_if;

    logic       iniciar;
    logic       pausa;
    logic       fez_jogada;
    logic       jogada_igual_memoria;
    logic       deu_timeout;
    logic       ultima_jogada;
    logic       fim_timer_resultado;
    logic       zera_contador_jogada;
    logic       zera_contador_score;
    logic       zera_timer_resultado;
    logic       zera_timeout;
    logic       zeraR;
    logic       zera_tempo_de_jogo;
    logic       conta_score;
    logic       conta_jogada;
    logic       conta_timer_resultado;
    logic       conta_timeout;
    logic       registraR;
    logic       liga_led;
    logic       mostra_tempo_de_jogo;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, pausa, fez_jogada, jogada_igual_memoria, deu_timeout, ultima_jogada,
               fim_timer_resultado,
        output zera_contador_jogada, zera_contador_score, zera_timer_resultado, zera_timeout,
               zeraR, zera_tempo_de_jogo, conta_score, conta_jogada, conta_timer_resultado,
               conta_timeout, registraR, liga_led, mostra_tempo_de_jogo, acertou, errou, pronto,
               db_estado
    );

    modport slave (
        output iniciar, pausa, fez_jogada, jogada_igual_memoria, deu_timeout, ultima_jogada,
               fim_timer_resultado,
        input  zera_contador_jogada, zera_contador_score, zera_timer_resultado, zera_timeout,
               zeraR, zera_tempo_de_jogo, conta_score, conta_jogada, conta_timer_resultado,
               conta_timeout, registraR, liga_led, mostra_tempo_de_jogo, acertou, errou, pronto,
               db_estado
    );

endinterface

// File: rtl/contador_erros.sv
// Saturating miss counter; flags when the configured miss limit (0 = unlimited) is reached.
module contador_erros #(
    parameter int unsigned ERR_W     = 2,
    parameter int unsigned MAX_ERROS = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_zera,
    input  logic i_incrementa,
    output logic o_limite_atingido
);

    logic [ERR_W-1:0] r_erros;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_erros <= '0;
        end else if (i_zera) begin
            r_erros <= '0;
        end else if (i_incrementa && (r_erros != '1)) begin
            r_erros <= r_erros + 1'b1;
        end
    end

    assign o_limite_atingido = (MAX_ERROS != 0) && (32'(r_erros) >= MAX_ERROS);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control FSM sequencing an 8-round quiz game over the datapath.
// Optional pause support is built when PAUSA_EN is defined.
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int unsigned MAX_ERROS = MAX_ERROS_PADRAO,
    parameter int unsigned ERR_W     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_jogo_if.master bus
);

    estado_t r_estado;
    estado_t w_prox;
    saidas_t r_saidas;
    logic    w_limite;
    logic    w_pausa_ativa;

`ifdef PAUSA_EN
    assign w_pausa_ativa = bus.pausa && estado_pausavel(r_estado);
`else
    assign w_pausa_ativa = 1'b0;
`endif

    contador_erros #(
        .ERR_W     (ERR_W),
        .MAX_ERROS (MAX_ERROS)
    ) u_contador_erros (
        .clock             (clock),
        .reset             (reset),
        .i_zera            (r_estado == StPrepara),
        .i_incrementa      (r_estado == StErro),
        .o_limite_atingido (w_limite)
    );

    always_comb begin
        w_prox = r_estado;
        if (!w_pausa_ativa) begin
            case (r_estado)
                StInicial:      if (bus.iniciar) w_prox = StPrepara;
                StPrepara:      w_prox = StMostra;
                StMostra:       if (bus.fim_timer_resultado) w_prox = StZeraT;
                StZeraT:        w_prox = StEspera;
                StEspera: begin
                    if (bus.fez_jogada)       w_prox = StRegistra;
                    else if (bus.deu_timeout) w_prox = StErro;
                end
                StRegistra:     w_prox = StCompara;
                StCompara:      w_prox = bus.jogada_igual_memoria ? StAcerto : StErro;
                StAcerto:       w_prox = StContaAcerto;
                StContaAcerto:  w_prox = StResultAcerto;
                StResultAcerto: if (bus.fim_timer_resultado) w_prox = StProxima;
                StErro:         w_prox = StResultErro;
                StResultErro:   if (bus.fim_timer_resultado) w_prox = StProxima;
                StProxima:      w_prox = (bus.ultima_jogada || w_limite) ? StFim : StMostra;
                StFim:          if (bus.iniciar) w_prox = StPrepara;
                default:        w_prox = StInicial;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_estado.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= StInicial;
            r_saidas <= '0;
        end else begin
            r_estado <= w_prox;
            r_saidas <= decodifica_saidas(w_prox);
        end
    end

    assign bus.zera_contador_jogada  = r_saidas.zera_contador_jogada;
    assign bus.zera_contador_score   = r_saidas.zera_contador_score;
    assign bus.zera_timer_resultado  = r_saidas.zera_timer_resultado;
    assign bus.zera_timeout          = r_saidas.zera_timeout;
    assign bus.zeraR                 = r_saidas.zeraR;
    assign bus.zera_tempo_de_jogo    = r_saidas.zera_tempo_de_jogo;
    assign bus.conta_score           = r_saidas.conta_score && !w_pausa_ativa;
    assign bus.conta_timer_resultado = r_saidas.conta_timer_resultado && !w_pausa_ativa;
    assign bus.conta_timeout         = r_saidas.conta_timeout && !w_pausa_ativa;
    assign bus.registraR             = r_saidas.registraR;
    assign bus.liga_led              = r_saidas.liga_led;
    assign bus.mostra_tempo_de_jogo  = r_saidas.mostra_tempo_de_jogo;
    assign bus.acertou               = r_saidas.acertou;
    assign bus.errou                 = r_saidas.errou;
    assign bus.pronto                = r_saidas.pronto;
    assign bus.db_estado             = r_estado;

    // Advance the round counter only when the game continues, so it stops on the last question.
    assign bus.conta_jogada = (r_estado == StProxima) && !bus.ultima_jogada && !w_limite
                              && !w_pausa_ativa;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Self-checking bench for unidade_controle_jogo: game-level model plus directed scenarios.
module tb_unidade_controle_jogo;

    localparam int MAX_ERR = 3;
    localparam int SAT_ERR = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    unidade_controle_jogo_if u_if ();

    unidade_controle_jogo #(
        .MAX_ERROS (MAX_ERR),
        .ERR_W     (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    int total = 0;
    int bad   = 0;
    int m_estado = 0;
    int m_erros  = 0;
    int n_score = 0, n_jogada = 0, n_errou = 0, n_pausa = 0;
    logic errou_ant = 1'b0;

    function automatic logic pausavel(int s);
        return (s == 2) || (s == 4) || (s == 9) || (s == 11);
    endfunction

    // Game rules: which phase follows which, given the flags seen at the edge.
    function automatic int prox_modelo(int s, int e, logic ini, logic fez, logic igual,
                                       logic to, logic ult, logic fim, logic pz);
        if (pz && pausavel(s)) return s;
        case (s)
            0:  return ini ? 1 : 0;
            1:  return 2;
            2:  return fim ? 3 : 2;
            3:  return 4;
            4:  return fez ? 5 : (to ? 10 : 4);
            5:  return 6;
            6:  return igual ? 7 : 10;
            7:  return 8;
            8:  return 9;
            9:  return fim ? 12 : 9;
            10: return 11;
            11: return fim ? 12 : 11;
            12: return (ult || (MAX_ERR != 0 && e >= MAX_ERR)) ? 13 : 2;
            13: return ini ? 1 : 13;
            default: return 0;
        endcase
    endfunction

    // Bit order: zcj zcs ztr zto zR ztj cs cj ctr cto rR led mtj ac er pr
    function automatic logic [15:0] saida_modelo(int s, int e, logic ult, logic pz);
        logic [15:0] v;
        case (s)
            1:  v = 16'hFC00;
            2:  v = 16'h0090;
            3:  v = 16'h3800;
            4:  v = 16'h0040;
            5:  v = 16'h0020;
            8:  v = 16'h0200;
            9:  v = 16'h0084;
            11: v = 16'h0082;
            12: v = 16'h2000;
            13: v = 16'h0009;
            default: v = 16'h0000;
        endcase
        if (s == 12 && !ult && !(MAX_ERR != 0 && e >= MAX_ERR)) v[8] = 1'b1;
        if (pz && pausavel(s)) v[9:6] = 4'b0000;
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_estado <= 0;
            m_erros  <= 0;
        end else begin
            m_estado <= prox_modelo(m_estado, m_erros, u_if.iniciar, u_if.fez_jogada,
                                    u_if.jogada_igual_memoria, u_if.deu_timeout,
                                    u_if.ultima_jogada, u_if.fim_timer_resultado, u_if.pausa);
            if (m_estado == 1)                          m_erros <= 0;
            else if (m_estado == 10 && m_erros < SAT_ERR) m_erros <= m_erros + 1;
        end
    end

    function automatic logic [15:0] saidas_dut();
        return {u_if.zera_contador_jogada, u_if.zera_contador_score, u_if.zera_timer_resultado,
                u_if.zera_timeout, u_if.zeraR, u_if.zera_tempo_de_jogo, u_if.conta_score,
                u_if.conta_jogada, u_if.conta_timer_resultado, u_if.conta_timeout,
                u_if.registraR, u_if.liga_led, u_if.mostra_tempo_de_jogo, u_if.acertou,
                u_if.errou, u_if.pronto};
    endfunction

    task automatic compara();
        logic [19:0] got, exp;
        got = {u_if.db_estado, saidas_dut()};
        exp = {4'(m_estado), saida_modelo(m_estado, m_erros, u_if.ultima_jogada, u_if.pausa)};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL ciclo t=%0t: estado/saidas got=%h exp=%h", $time, got, exp);
        end
        if (u_if.conta_score)  n_score++;
        if (u_if.conta_jogada) n_jogada++;
        if (u_if.errou && !errou_ant) n_errou++;
        errou_ant = u_if.errou;
        if (u_if.pausa && u_if.db_estado == 4'h4 && !u_if.conta_timeout) n_pausa++;
    endtask

    task automatic passo();
        @(negedge clock);
        compara();
        #2;
    endtask

    task automatic verifica(input string nome, input int atual, input int esperado);
        total++;
        if (atual != esperado) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", nome, atual, esperado);
        end
    endtask

    task automatic espera_estado(input int cod, input int limite);
        for (int i = 0; i < limite; i++) begin
            if (int'(u_if.db_estado) == cod) return;
            passo();
        end
        total++;
        bad++;
        $display("FAIL timeout esperando estado: got=%0d exp=%0d", u_if.db_estado, cod);
    endtask

    initial begin
        u_if.iniciar = 0; u_if.pausa = 0; u_if.fez_jogada = 0; u_if.jogada_igual_memoria = 0;
        u_if.deu_timeout = 0; u_if.ultima_jogada = 0; u_if.fim_timer_resultado = 0;
        repeat (3) passo();
        verifica("reset_estado", int'(u_if.db_estado), 0);
        verifica("reset_saidas", int'(saidas_dut()), 0);
        reset = 1'b1;
        passo();

        // Async reset in the middle of ESPERA
        u_if.fim_timer_resultado = 1;
        u_if.iniciar = 1; passo(); u_if.iniciar = 0;
        espera_estado(4, 10);
        #1 reset = 1'b0;
        #1;
        verifica("reset_async_estado", int'(u_if.db_estado), 0);
        verifica("reset_async_saidas", int'(saidas_dut()), 0);
        passo();
        reset = 1'b1;
        passo();

        // Eight correct answers
        n_score = 0; n_jogada = 0;
        u_if.iniciar = 1; passo(); u_if.iniciar = 0;
        for (int r = 1; r <= 8; r++) begin
            espera_estado(4, 20);
            u_if.fez_jogada = 1; u_if.jogada_igual_memoria = 1;
            u_if.ultima_jogada = (r == 8);
            passo();
            u_if.fez_jogada = 0;
        end
        espera_estado(13, 20);
        verifica("acertos_conta_score", n_score, 8);
        verifica("acertos_conta_jogada", n_jogada, 7);
        verifica("acertos_pronto", int'(u_if.pronto), 1);
        verifica("acertos_estado_fim", int'(u_if.db_estado), 13);
        u_if.ultima_jogada = 0;
        passo();
        verifica("fim_mantem", int'(u_if.db_estado), 13);

        // Three timeouts end the game early
        n_score = 0; n_jogada = 0; n_errou = 0;
        u_if.iniciar = 1; passo(); u_if.iniciar = 0;
        for (int r = 1; r <= 3; r++) begin
            espera_estado(4, 20);
            u_if.deu_timeout = 1;
            passo();
            u_if.deu_timeout = 0;
        end
        espera_estado(13, 20);
        verifica("timeouts_errou", n_errou, 3);
        verifica("timeouts_score", n_score, 0);
        verifica("timeouts_jogada", n_jogada, 2);
        verifica("timeouts_estado_fim", int'(u_if.db_estado), 13);
        verifica("modelo_erros_sat", m_erros, 3);

        // Press and timeout together, then a wrong answer
        u_if.iniciar = 1; passo(); u_if.iniciar = 0;
        espera_estado(4, 20);
        u_if.fez_jogada = 1; u_if.deu_timeout = 1;
        passo();
        u_if.fez_jogada = 0; u_if.deu_timeout = 0;
        verifica("ambos_registra", int'(u_if.db_estado), 5);
        verifica("ambos_sem_errou", int'(u_if.errou), 0);
        u_if.jogada_igual_memoria = 0; u_if.fim_timer_resultado = 0;
        n_errou = 0; n_jogada = 0;
        espera_estado(11, 10);
        repeat (3) passo();
        verifica("errado_segura_errou", int'(u_if.errou), 1);
        verifica("errado_segura_estado", int'(u_if.db_estado), 11);
        u_if.fim_timer_resultado = 1;
        espera_estado(2, 10);
        verifica("errado_janelas", n_errou, 1);
        verifica("errado_continua", n_jogada, 1);
        verifica("modelo_erros_um", m_erros, 1);

`ifdef PAUSA_EN
        espera_estado(4, 10);
        n_pausa = 0;
        u_if.pausa = 1;
        repeat (50) passo();
        u_if.pausa = 0;
        verifica("pausa_ciclos", n_pausa, 50);
        verifica("pausa_estado", int'(u_if.db_estado), 4);
        passo();
        verifica("pausa_retoma", int'(u_if.conta_timeout), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
